// File: rtl/serial_carry_adder.sv
// Bit-serial N-bit adder: one full-adder slice per clock, LSB first, with a registered carry.
// Accepts a start in IDLE or DONE and publishes sum/carry only on the completing edge.
module serial_carry_adder #(
  parameter int unsigned N = 16
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [N-1:0] iA,
  input  logic [N-1:0] iB,
  input  logic         iCarry,
  output logic [N-1:0] oSum,
  output logic         oCarry,
  output logic         oBusy,
  output logic         oDone
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_sh_q, a_sh_d;
  logic [N-1:0]    b_sh_q, b_sh_d;
  logic [N-2:0]    s_sh_q, s_sh_d;
  logic            c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            sum_bit_c;
  logic            cout_c;
  logic [N-1:0]    shifted_c;

  // Single full-adder slice fed by the operand LSBs and the carry register
  always_comb begin
    sum_bit_c = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    cout_c    = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    shifted_c = {sum_bit_c, s_sh_q};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (iStart) begin
          a_sh_d  = iA;
          b_sh_d  = iB;
          s_sh_d  = '0;
          c_d     = iCarry;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = {1'b0, a_sh_q[N-1:1]};
        b_sh_d = {1'b0, b_sh_q[N-1:1]};
        s_sh_d = shifted_c[N-1:1];
        c_d    = cout_c;
        cnt_d  = cnt_q + CW'(1);
        // Last bit: publish the full result in the same edge
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = shifted_c;
          carry_d = cout_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign oSum   = sum_q;
  assign oCarry = carry_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;

endmodule
